// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// one-hot FSM state encoding, parity-mode names and the bit-period helper.
package uart_pkg;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    CHECK = 5'b01000,
    STOP  = 5'b10000
  } uart_state_e;

  localparam string PARITY_NONE = "None";
  localparam string PARITY_EVEN = "Even";
  localparam string PARITY_ODD  = "Odd";

  // Clock cycles per UART bit (integer division, remainder dropped).
  function automatic int bit_cyc(input int clock, input int baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// 4-entry x 8-bit synchronous FIFO with show-ahead read data. It sits in
// front of the uart_tx serialiser when UART_TX_FIFO_EN is defined.
module uart_tx_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] pop_data_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       push_ok, pop_ok;

  assign full_o     = (count_q == 3'd4);
  assign empty_o    = (count_q == 3'd0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {1'b0, push_ok};
    rd_ptr_d = rd_ptr_q + {1'b0, pop_ok};
    count_d  = count_q + {2'b00, push_ok} - {2'b00, pop_ok};
  end

  // Control state; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// one stop bit. Bytes enter through a valid/ready handshake.
// Optional macro UART_TX_FIFO_EN puts a 4-entry FIFO (uart_tx_fifo) in front
// of the serialiser; without it a byte is only taken while the line is idle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int    CLOCK     = 50_000_000,
  parameter int    BAUD      = 9600,
  parameter string CHECK_BIT = "None"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_data_vld,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx
);

  localparam int BIT_CYC = bit_cyc(CLOCK, BAUD);
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYC - 1);

  // Unknown parity strings fall back to no parity bit.
  localparam bit PAR_ODD = (CHECK_BIT == PARITY_ODD);
  localparam bit PAR_EN  = (CHECK_BIT == PARITY_EVEN) || PAR_ODD;

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_end;
  logic             load;
  logic [7:0]       load_data;

`ifdef UART_TX_FIFO_EN
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0] fifo_rd_data;

  assign fifo_push = tx_data_vld && !fifo_full;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign tx_ready  = !fifo_full;
  assign load      = fifo_pop;
  assign load_data = fifo_rd_data;

  uart_tx_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_data_i(tx_data),
    .pop_i      (fifo_pop),
    .pop_data_o (fifo_rd_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );
`else
  assign tx_ready  = (state_q == IDLE);
  assign load      = tx_data_vld && tx_ready;
  assign load_data = tx_data;
`endif

  assign bit_end = (cnt_q == CNT_MAX);
  assign tx      = tx_q;
  assign tx_done = done_q;

  // Next state, baud/bit counters and the line level for the current state.
  // tx is registered from the current state, so the line trails the state by one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    done_d    = 1'b0;
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = START;
          shift_d   = load_data;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[bit_cnt_q];
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PAR_EN ? CHECK : STOP;
        end
      end
      CHECK: begin
        tx_d = PAR_ODD ? ~^shift_q : ^shift_q;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // Captured byte; pure data, held until the next accepted byte.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLOCK=16, BAUD=1 (16 cycles per bit), with one
// instance per parity mode. Frames are compared cycle by cycle against
// hand-written bit patterns; UART_TX_FIFO_EN selects the FIFO sequence.
module tb_uart_tx;

  localparam int BC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       vld     [3];
  logic       tx_w    [3];
  logic       done_w  [3];
  logic       ready_w [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLOCK(16), .BAUD(1), .CHECK_BIT("None")) u_none (
    .clk(clk), .rst(rst), .tx_data_vld(vld[0]), .tx_data(data),
    .tx_ready(ready_w[0]), .tx_done(done_w[0]), .tx(tx_w[0]));
  uart_tx #(.CLOCK(16), .BAUD(1), .CHECK_BIT("Even")) u_even (
    .clk(clk), .rst(rst), .tx_data_vld(vld[1]), .tx_data(data),
    .tx_ready(ready_w[1]), .tx_done(done_w[1]), .tx(tx_w[1]));
  uart_tx #(.CLOCK(16), .BAUD(1), .CHECK_BIT("Odd")) u_odd (
    .clk(clk), .rst(rst), .tx_data_vld(vld[2]), .tx_data(data),
    .tx_ready(ready_w[2]), .tx_done(done_w[2]), .tx(tx_w[2]));

  // inst: 0 None, 1 Even, 2 Odd. exp bit i is line bit i (bit 0 = start).
  typedef struct packed {
    logic [1:0]  inst;
    logic [7:0]  d;
    logic [3:0]  nbits;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send(input int inst, input logic [7:0] d);
    @(negedge clk);
    data      = d;
    vld[inst] = 1'b1;
    @(posedge clk);
    #1;
    vld[inst] = 1'b0;
  endtask

  // Called #1 after the accepting edge k; walks edges k+1 .. k+len+1.
  task automatic run_frame(input int inst, input logic [10:0] exp, input int nbits, input int id);
    int  len   = nbits * BC;
    int  e_tx  = 0;
    int  e_dn  = 0;
    int  e_rdy = 0;
    logic want;
    check($sformatf("v%0d_accept", id), {29'd0, tx_w[inst], ready_w[inst], done_w[inst]}, 32'b100);
    for (int c = 0; c <= len; c++) begin
      @(posedge clk);
      #1;
      want = 1'b1;
      if (c < len) want = exp[c / BC];
      if (tx_w[inst] !== want) e_tx++;
      if (done_w[inst] !== (c == len - 1)) e_dn++;
      if (ready_w[inst] !== (c >= len - 1)) e_rdy++;
    end
    check($sformatf("v%0d_tx_wave", id), e_tx, 0);
    check($sformatf("v%0d_done", id), e_dn, 0);
    check($sformatf("v%0d_ready", id), e_rdy, 0);
  endtask

  // Line decoder: bounded wait for a start bit, then mid-bit sampling.
  task automatic rx_byte(input int inst, output logic [7:0] b, output logic ok);
    int t = 0;
    b  = '0;
    ok = 1'b0;
    while (tx_w[inst] !== 1'b0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (tx_w[inst] !== 1'b0) return;
    repeat (8) @(posedge clk);
    #1;
    if (tx_w[inst] !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (BC) @(posedge clk);
      #1;
      b[i] = tx_w[inst];
    end
    repeat (BC) @(posedge clk);
    #1;
    ok = (tx_w[inst] === 1'b1);
  endtask

  initial begin
    logic [10:0] f1, f2;
    logic        want;
    int          e_tx, e_dn, e_rdy;

    vecs[0] = '{2'd0, 8'h55, 4'd10, 11'b1_1_01010101_0};
    vecs[1] = '{2'd1, 8'hA3, 4'd11, 11'b1_0_10100011_0};
    vecs[2] = '{2'd2, 8'hA3, 4'd11, 11'b1_1_10100011_0};
    vecs[3] = '{2'd1, 8'h00, 4'd11, 11'b1_0_00000000_0};
    vecs[4] = '{2'd2, 8'h00, 4'd11, 11'b1_1_00000000_0};
    vecs[5] = '{2'd0, 8'hFF, 4'd10, 11'b1_1_11111111_0};
    vecs[6] = '{2'd1, 8'h80, 4'd11, 11'b1_1_10000000_0};
    vecs[7] = '{2'd2, 8'h7F, 4'd11, 11'b1_0_01111111_0};

    rst  = 1'b1;
    data = 8'h00;
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_%0d", i), {29'd0, tx_w[i], ready_w[i], done_w[i]}, 32'b110);
    @(negedge clk);
    rst = 1'b0;

`ifdef UART_TX_FIFO_EN
    begin
      logic [7:0] bytes [6];
      logic [7:0] got;
      logic       ok;
      int         lows;
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
      bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
      // Byte 0 is popped one edge after its push, so five pushes fill the FIFO.
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        data   = bytes[i];
        vld[0] = 1'b1;
        check($sformatf("fifo_ready_%0d", i), {31'd0, ready_w[0]}, (i < 5) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        if (i == 1) check("fifo_lat_k1", {31'd0, tx_w[0]}, 32'd1);
        if (i == 2) check("fifo_lat_k2", {31'd0, tx_w[0]}, 32'd0);
      end
      @(negedge clk);
      vld[0] = 1'b0;
      check("fifo_full", {31'd0, ready_w[0]}, 32'd0);
      for (int i = 0; i < 5; i++) begin
        rx_byte(0, got, ok);
        check($sformatf("fifo_byte_%0d", i), {23'd0, ok, got}, {23'd0, 1'b1, bytes[i]});
        if (i == 1) check("fifo_ready_back", {31'd0, ready_w[0]}, 32'd1);
      end
      lows = 0;
      for (int c = 0; c < 200; c++) begin
        @(posedge clk);
        #1;
        if (tx_w[0] !== 1'b1) lows++;
      end
      check("fifo_no_extra", lows, 0);
    end
`else
    // Table of single frames across the three parity modes.
    for (int v = 0; v < 8; v++) begin
      send(int'(vecs[v].inst), vecs[v].d);
      run_frame(int'(vecs[v].inst), vecs[v].exp, int'(vecs[v].nbits), v);
    end

    // Back-to-back with vld held: 0x01 then 0x80, data changed mid-frame.
    f1 = 11'b1_1_00000001_0;
    f2 = 11'b1_1_10000000_0;
    @(negedge clk);
    data   = 8'h01;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    data = 8'h80;
    check("b2b_accept", {30'd0, tx_w[0], ready_w[0]}, 32'b10);
    e_tx = 0; e_dn = 0; e_rdy = 0;
    for (int c = 0; c <= 320; c++) begin
      @(posedge clk);
      #1;
      if (c == 160) vld[0] = 1'b0;
      if (c < 160)       want = f1[c / BC];
      else if (c == 160) want = 1'b1;
      else               want = f2[(c - 161) / BC];
      if (tx_w[0] !== want) e_tx++;
      if (done_w[0] !== (c == 159 || c == 320)) e_dn++;
      if (ready_w[0] !== (c == 159 || c == 320)) e_rdy++;
    end
    check("b2b_tx_wave", e_tx, 0);
    check("b2b_done", e_dn, 0);
    check("b2b_ready", e_rdy, 0);

    // Reset 50 cycles into a 0x00 frame, then 0xFF right after release.
    send(0, 8'h00);
    e_tx = 0; e_dn = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (tx_w[0] !== 1'b0) e_tx++;
      if (done_w[0] !== 1'b0) e_dn++;
    end
    check("rst_pre_tx", e_tx, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_frame", {29'd0, tx_w[0], ready_w[0], done_w[0]}, 32'b110);
    @(negedge clk);
    rst    = 1'b0;
    data   = 8'hFF;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    check("rst_no_done", e_dn, 0);
    run_frame(0, 11'b1_1_11111111_0, 10, 8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
